// File: rtl/thermometer_decoder_if.sv
// thermometer_decoder_if: comparator capture inputs and coded valid/ready output bundle
interface thermometer_decoder_if #(
  parameter int OUT_W = 4,
  parameter int N_CMP = 2**OUT_W-1
);
  logic [N_CMP-1:0] therm_in;
  logic             sample_en;
  logic [OUT_W-1:0] code_out;
  logic             code_valid;
  logic             code_ready;
  logic             bubble_err;
  logic             overrange;
  logic [7:0]       drop_cnt;
  modport master (
    input  therm_in, sample_en, code_ready,
    output code_out, code_valid, bubble_err, overrange, drop_cnt
  );
  modport slave (
    output therm_in, sample_en, code_ready,
    input  code_out, code_valid, bubble_err, overrange, drop_cnt
  );
endinterface

// File: rtl/thermometer_decoder.sv
// thermometer_decoder: synchronize comparator word, remove bubbles, ones-count to binary, valid/ready out
module thermometer_decoder #(
  parameter int OUT_W       = 4,
  parameter int N_CMP       = 2**OUT_W-1,
  parameter int SYNC_STAGES = 2
) (
  input logic clk,
  input logic rst,
  thermometer_decoder_if.master bus
);
  logic [N_CMP-1:0]   sync_q [SYNC_STAGES];
  logic [SYNC_STAGES-1:0] en_q;
  logic [N_CMP-1:0]   t, c_d;
  logic [N_CMP+1:0]   ext;
  logic [OUT_W-1:0]   cnt_d, cnt_q, code_q;
  logic               bub_q, ovr_q, stv_q;
  logic               valid_q, err_q, rng_q;
  logic [7:0]         drop_q;
  logic               load, drop;
  // synchronizer: comparators are live, so the chain shifts every cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      en_q <= '0;
    end else begin
      sync_q[0] <= bus.therm_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      en_q <= {en_q[SYNC_STAGES-2:0], bus.sample_en};
    end
  end
  assign t   = sync_q[SYNC_STAGES-1];
  assign ext = {1'b0, t, 1'b1};
  // majority filter over each bit and its neighbours, then ones-count of the result
  always_comb begin
    c_d   = '0;
    cnt_d = '0;
    for (int i = 0; i < N_CMP; i++) begin
      c_d[i] = (ext[i] & ext[i+1]) | (ext[i] & ext[i+2]) | (ext[i+1] & ext[i+2]);
      cnt_d  = cnt_d + OUT_W'(c_d[i]);
    end
  end
  // correct stage register: code, flags and stage valid
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      bub_q <= 1'b0;
      ovr_q <= 1'b0;
      stv_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      bub_q <= c_d != t;
      ovr_q <= &c_d;
      stv_q <= en_q[SYNC_STAGES-1];
    end
  end
  assign load = stv_q && (!valid_q || bus.code_ready);
  assign drop = stv_q && valid_q && !bus.code_ready;
  // output register: load when free or draining, otherwise drop and count
  always_ff @(posedge clk) begin
    if (rst) begin
      code_q  <= '0;
      err_q   <= 1'b0;
      rng_q   <= 1'b0;
      valid_q <= 1'b0;
      drop_q  <= '0;
    end else begin
      if (load) {code_q, err_q, rng_q} <= {cnt_q, bub_q, ovr_q};
      valid_q <= load || (valid_q && !bus.code_ready);
      if (drop && drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
    end
  end
  assign bus.code_out   = code_q;
  assign bus.code_valid = valid_q;
  assign bus.bubble_err = err_q;
  assign bus.overrange  = rng_q;
  assign bus.drop_cnt   = drop_q;
endmodule
